matvec_fifo_loader: RTL and testbench
=====================================

# matvec_fifo_loader

Upstream fill stage for the 8-MAC matrix-vector datapath. On a start pulse it fetches the 8x8 matrix A and the 8-element vector B from a word-addressed memory, one 64-bit word per row, and writes them byte-serially into the eight A-row FIFOs and the single B FIFO. When every byte is written it signals done, and the MAC array can begin draining the FIFOs.

## Interface
- DATA_WIDTH, 8, element width in bits.
- ROWS, 8, number of A rows, A FIFOs, and elements per word.
- ADDR_WIDTH, 32, memory address width.
- BASE_ADDR, 0, word address of A row 0. Row r is at BASE_ADDR+r. B is at BASE_ADDR+ROWS.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to load. Sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when all ROWS+1 words have been written.
- mem_address  out  ADDR_WIDTH  read address.
- mem_read  out  1  read request.
- mem_waitrequest  in  1  memory stall. The request is accepted on a cycle with mem_read=1 and mem_waitrequest=0.
- mem_readdata  in  DATA_WIDTH*ROWS  read word.
- mem_readdatavalid  in  1  mem_readdata is valid this cycle.
- fifo_wdata  out  DATA_WIDTH  shared write data to all FIFOs.
- fifo_wrreq  out  ROWS+1  one-hot write strobe. Bits [ROWS-1:0] drive the A-row FIFOs; bit ROWS drives the B FIFO.
- fifo_wrfull  in  ROWS+1  full flags, indexed the same way as fifo_wrreq.

## Operation
- States and transitions:
  - IDLE: on start, go to REQ.
  - REQ: on accept, go to WAIT.
  - WAIT: on mem_readdatavalid, go to WRITE.
  - WRITE: after the 8th accepted byte, go to REQ if row<ROWS, otherwise go to DONE.
  - DONE: go to IDLE after one cycle.
- Row counter: 0..ROWS, reset to 0 on start. Byte counter: 0..ROWS-1, reset to 0 on entering WRITE.
- REQ: mem_read=1 and mem_address=BASE_ADDR+row. Both are held stable until accepted.
- At most one read is outstanding. mem_readdatavalid outside WAIT is ignored.
- WAIT: mem_readdata is captured into a word register when mem_readdatavalid=1.
- WRITE:
  - fifo_wdata = byte[byte_cnt] of the captured word. Byte 0 is bits [DATA_WIDTH-1:0].
  - fifo_wrreq[row] = !fifo_wrfull[row]. This is combinational from wrfull, and only one bit is ever high.
  - byte_cnt advances only on cycles with wrreq high. A full FIFO stalls the load indefinitely and no byte is lost.
- Target index: row r<ROWS writes FIFO r; row ROWS writes the B FIFO (bit ROWS).
- DONE: done=1 for exactly one cycle. busy drops in the same cycle.
- start while busy or in DONE is ignored; it is neither queued nor restarted.

## Timing
- Reset values: state IDLE, busy 0, done 0, mem_read 0, mem_address BASE_ADDR, fifo_wrreq 0, fifo_wdata 0, all counters 0.
- Asynchronous reset mid-load drops all outputs immediately. Partial FIFO contents are the FIFOs' own concern; their aclr is driven separately.
- Start sampled high at edge 0 gives REQ in cycle 1.
- With mem_waitrequest=0, readdatavalid exactly one cycle after accept, and no FIFO full:
  - row k occupies cycles 10k+1..10k+10 (REQ, WAIT, then 8 WRITE cycles).
  - done is high in cycle 91.
- Each waitrequest cycle, each extra read-latency cycle, and each full cycle adds exactly one cycle.
- mem_readdatavalid in the same cycle the request is accepted is not supported; data is expected at least one cycle later.

## Configuration
- MATVEC_LOADER_MSB_FIRST_EN:
  - defined: bytes are written from the most-significant byte (bits [DATA_WIDTH*ROWS-1 -: DATA_WIDTH]) down to byte 0.
  - undefined: bytes are written from byte 0 up to byte ROWS-1.
  - Cycle timing is identical in both cases.

## Test plan
- Single load, no stalls: memory word r=0x0706050403020100+r*0x0808080808080808, B=0x1111111111111111, start. Required:
  - FIFO r receives 8r..8r+7 in ascending order.
  - B FIFO receives eight 0x11.
  - done is high in cycle 91, once only.
- Memory stalls: waitrequest high 3 cycles on every request and readdatavalid latency 4. Required:
  - same FIFO contents as the no-stall case.
  - mem_address and mem_read stable through each stall.
  - done in cycle 1+9*(4+4+8).
- FIFO full: hold fifo_wrfull[3] high for 5 cycles starting at row 3 byte 2. Required:
  - no wrreq during the full cycles.
  - byte 2 is written after the full flag drops.
  - done is late by exactly 5 cycles.
- start pulsed at cycle 20 during a load. Required: ignored, 72 writes total, one done pulse.
- rst_n asserted in cycle 40, then a new start. Required:
  - all outputs are 0 asynchronously.
  - the restarted load reads from BASE_ADDR again.
  - done in cycle 91 after the new start.
- With MATVEC_LOADER_MSB_FIRST_EN defined, repeat the first scenario. Required: FIFO r receives 8r+7 down to 8r.

Source files
------------

// File: rtl/matvec_fifo_loader.sv
// Fill stage for the matrix-vector MAC array: fetches ROWS A-rows plus the B vector
// from memory and writes them byte-serially into the A-row FIFOs and the B FIFO.
// Optional MATVEC_LOADER_MSB_FIRST_EN: write each word most-significant byte first.
module matvec_fifo_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int BASE_ADDR  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_WIDTH-1:0]      mem_address,
  output logic                       mem_read,
  input  logic                       mem_waitrequest,
  input  logic [DATA_WIDTH*ROWS-1:0] mem_readdata,
  input  logic                       mem_readdatavalid,
  output logic [DATA_WIDTH-1:0]      fifo_wdata,
  output logic [ROWS:0]              fifo_wrreq,
  input  logic [ROWS:0]              fifo_wrfull
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int BW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS);
  localparam logic [BW-1:0] LAST_BYTE = BW'(ROWS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                 r_state;
  logic [RW-1:0]              r_row;
  logic [BW-1:0]              r_byteCnt;
  logic [DATA_WIDTH*ROWS-1:0] r_word;

  logic [BW-1:0] w_byteSel;
  logic          w_accept;
  logic          w_wrFire;
  logic [ROWS:0] w_wrreq;

`ifdef MATVEC_LOADER_MSB_FIRST_EN
  assign w_byteSel = LAST_BYTE - r_byteCnt;
`else
  assign w_byteSel = r_byteCnt;
`endif

  assign w_accept = (r_state == S_REQ) && !mem_waitrequest;
  // Row index doubles as the FIFO select: row ROWS lands on the B FIFO bit.
  assign w_wrFire = (r_state == S_WRITE) && !fifo_wrfull[r_row];

  always_comb begin
    w_wrreq = '0;
    if (w_wrFire) w_wrreq[r_row] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_byteCnt <= '0;
      r_word    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row   <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_accept) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_readdatavalid) begin
            r_word    <= mem_readdata;
            r_byteCnt <= '0;
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_wrFire) begin
            if (r_byteCnt == LAST_BYTE) begin
              if (r_row == LAST_ROW) begin
                r_state <= S_DONE;
              end else begin
                r_row   <= r_row + 1'b1;
                r_state <= S_REQ;
              end
            end else begin
              r_byteCnt <= r_byteCnt + 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_WRITE);
  assign done        = (r_state == S_DONE);
  assign mem_read    = (r_state == S_REQ);
  assign mem_address = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_row);
  assign fifo_wdata  = r_word[w_byteSel*DATA_WIDTH +: DATA_WIDTH];
  assign fifo_wrreq  = w_wrreq;

endmodule

// File: tb/tb_matvec_fifo_loader.sv
// Self-checking bench for matvec_fifo_loader: a memory responder and FIFO recorder
// run beside the DUT, and each test compares what landed in the FIFOs against memory.
`timescale 1ns/1ps
module tb_matvec_fifo_loader;
  localparam int DW = 8;
  localparam int NR = 8;
  localparam int AW = 32;
  localparam int BASE = 0;
  localparam int WW = DW * NR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic          mem_waitrequest;
  logic [WW-1:0] mem_readdata;
  logic          mem_readdatavalid;
  logic [DW-1:0] fifo_wdata;
  logic [NR:0]   fifo_wrreq;
  logic [NR:0]   fifo_wrfull;

  matvec_fifo_loader #(.DATA_WIDTH(DW), .ROWS(NR), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .fifo_wdata(fifo_wdata), .fifo_wrreq(fifo_wrreq), .fifo_wrfull(fifo_wrfull)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] memWord [0:NR];
  logic [DW-1:0] fifoLog [0:NR][0:15];
  int            wrCnt [0:NR];
  int compared, mismatched;
  int cfgWait, cfgLat, stallSeen, respCnt, respIdx, reqCount;
  bit prevStalled, firstAddrSeen, busyCheckEn, fullArm;
  logic [AW-1:0] stallAddr, firstAddr;
  int writeTotal, doneCount, doneCycle, byte2Cycle, fullLeft;
  int cyc, startBase, rel;
  logic expBusy;

  function automatic logic [WW-1:0] gotRow(input int r);
    logic [WW-1:0] v = '0;
    for (int j = 0; j < NR; j++) v[j*DW +: DW] = fifoLog[r][j];
    return v;
  endfunction

  // Expected FIFO contents: byte j received is byte j of the word, or byte NR-1-j when MSB-first.
  function automatic logic [WW-1:0] expRow(input int r);
    logic [WW-1:0] v = '0;
    for (int j = 0; j < NR; j++) begin
`ifdef MATVEC_LOADER_MSB_FIRST_EN
      v[j*DW +: DW] = memWord[r][(NR-1-j)*DW +: DW];
`else
      v[j*DW +: DW] = memWord[r][j*DW +: DW];
`endif
    end
    return v;
  endfunction

  // Memory responder and FIFO recorder: inputs driven just after each edge, outputs sampled mid-cycle.
  initial begin
    cyc = 0; cfgWait = 0; cfgLat = 1; stallSeen = 0; respCnt = 0; respIdx = 0;
    prevStalled = 0; fullArm = 0; fullLeft = 0; busyCheckEn = 0; reqCount = 0;
    mem_waitrequest = 0; mem_readdatavalid = 0; mem_readdata = '0; fifo_wrfull = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mem_readdatavalid = 0;
      mem_readdata = {$urandom, $urandom};
      fifo_wrfull = '0;
      if (rst_n !== 1'b1) begin
        mem_waitrequest = 0; respCnt = 0; stallSeen = 0; prevStalled = 0;
      end else begin
        if (respCnt > 0) begin
          respCnt--;
          if (respCnt == 0) begin
            mem_readdatavalid = 1;
            mem_readdata = (respIdx >= 0 && respIdx <= NR) ? memWord[respIdx] : 'x;
          end
        end
        if (prevStalled) begin
          compared++;
          if (mem_read !== 1'b1 || mem_address !== stallAddr) begin
            mismatched++;
            $display("[TB] FAIL stall_hold: read=%b addr=%h, want read=1 addr=%h", mem_read, mem_address, stallAddr);
          end
        end
        mem_waitrequest = 0;
        prevStalled = 0;
        if (mem_read === 1'b1) begin
          if (stallSeen < cfgWait) begin
            mem_waitrequest = 1; stallSeen++; prevStalled = 1; stallAddr = mem_address;
          end else begin
            stallSeen = 0; respIdx = int'(mem_address) - BASE; respCnt = cfgLat; reqCount++;
            if (!firstAddrSeen) begin firstAddrSeen = 1; firstAddr = mem_address; end
          end
        end
        if (fullArm && wrCnt[3] == 2 && fullLeft > 0) begin
          fifo_wrfull[3] = 1'b1;
          fullLeft--;
        end
      end
      @(negedge clk);
      if (rst_n === 1'b1) begin
        rel = cyc - startBase;
        if (fifo_wrreq !== '0) begin
          compared++;
          if ($countones(fifo_wrreq) != 1) begin
            mismatched++;
            $display("[TB] FAIL wrreq_onehot: wrreq=%b, want exactly one bit", fifo_wrreq);
          end
        end
        for (int i = 0; i <= NR; i++) begin
          if (fifo_wrfull[i]) begin
            compared++;
            if (fifo_wrreq[i] !== 1'b0) begin
              mismatched++;
              $display("[TB] FAIL full_block: fifo %0d wrreq=%b while full, want 0", i, fifo_wrreq[i]);
            end
          end else if (fifo_wrreq[i] === 1'b1) begin
            if (i == 3 && wrCnt[3] == 2) byte2Cycle = rel;
            if (wrCnt[i] < 16) fifoLog[i][wrCnt[i]] = fifo_wdata;
            wrCnt[i]++;
            writeTotal++;
          end
        end
        if (busyCheckEn) begin
          expBusy = (rel >= 1 && rel <= 90);
          compared++;
          if (busy !== expBusy) begin
            mismatched++;
            $display("[TB] FAIL busy_window: cycle %0d busy=%b, want %b", rel, busy, expBusy);
          end
        end
        if (done === 1'b1) begin doneCount++; doneCycle = rel; end
      end
    end
  end

  task automatic launch();
    doneCount = 0; doneCycle = -1; writeTotal = 0; firstAddrSeen = 0; byte2Cycle = -1; reqCount = 0;
    for (int r = 0; r <= NR; r++) wrCnt[r] = 0;
    @(posedge clk); #2;
    start = 1; startBase = cyc;
    @(posedge clk); #2;
    start = 0;
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (doneCount == 0 && n < limit) begin @(posedge clk); #2; n++; end
    if (doneCount == 0) begin
      compared++; mismatched++;
      $display("[TB] FAIL done_timeout: no done within %0d cycles, want one", limit);
    end
    repeat (12) @(posedge clk);
    #2;
  endtask

  task automatic randomMemory();
    for (int r = 0; r <= NR; r++) memWord[r] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0;
    repeat (2) @(posedge clk);
    #4;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    compared++; if (mem_read !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_read: got %b want 0", mem_read); end
    compared++; if (mem_address !== AW'(BASE)) begin mismatched++; $display("[TB] FAIL reset_addr: got %h want %h", mem_address, AW'(BASE)); end
    compared++; if (fifo_wrreq !== '0) begin mismatched++; $display("[TB] FAIL reset_wrreq: got %b want 0", fifo_wrreq); end
    compared++; if (fifo_wdata !== '0) begin mismatched++; $display("[TB] FAIL reset_wdata: got %h want 0", fifo_wdata); end
    @(negedge clk); rst_n = 1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_no_stall();
    for (int r = 0; r < NR; r++) memWord[r] = 64'h0706050403020100 + 64'(r) * 64'h0808080808080808;
    memWord[NR] = 64'h1111111111111111;
    cfgWait = 0; cfgLat = 1;
    launch();
    busyCheckEn = 1;
    waitDone(200);
    busyCheckEn = 0;
    compared++; if (doneCycle != 91) begin mismatched++; $display("[TB] FAIL nostall_done_cycle: got %0d want 91", doneCycle); end
    compared++; if (doneCount != 1) begin mismatched++; $display("[TB] FAIL nostall_done_count: got %0d want 1", doneCount); end
    compared++; if (reqCount != NR + 1) begin mismatched++; $display("[TB] FAIL nostall_reads: got %0d want %0d", reqCount, NR + 1); end
    for (int r = 0; r <= NR; r++) begin
      compared++;
      if (wrCnt[r] != NR || gotRow(r) !== expRow(r)) begin
        mismatched++;
        $display("[TB] FAIL nostall_fifo%0d: got %h (%0d writes) want %h (8 writes)", r, gotRow(r), wrCnt[r], expRow(r));
      end
    end
  endtask

  task automatic test_mem_stalls();
    randomMemory();
    cfgWait = 3; cfgLat = 4;
    launch();
    waitDone(400);
    compared++; if (doneCycle != 1 + 9 * (4 + 4 + 8)) begin mismatched++; $display("[TB] FAIL stall_done_cycle: got %0d want %0d", doneCycle, 1 + 9 * 16); end
    for (int r = 0; r <= NR; r++) begin
      compared++;
      if (wrCnt[r] != NR || gotRow(r) !== expRow(r)) begin
        mismatched++;
        $display("[TB] FAIL stall_fifo%0d: got %h (%0d writes) want %h (8 writes)", r, gotRow(r), wrCnt[r], expRow(r));
      end
    end
    cfgWait = 0; cfgLat = 1;
  endtask

  task automatic test_random_stalls();
    int expDone;
    for (int it = 0; it < 3; it++) begin
      randomMemory();
      cfgWait = $urandom_range(0, 3);
      cfgLat = $urandom_range(1, 5);
      expDone = 1 + (NR + 1) * (cfgWait + cfgLat + 9);
      launch();
      waitDone(500);
      compared++;
      if (doneCycle != expDone || doneCount != 1) begin
        mismatched++;
        $display("[TB] FAIL rand_done: wait=%0d lat=%0d got cycle %0d x%0d want cycle %0d x1", cfgWait, cfgLat, doneCycle, doneCount, expDone);
      end
      for (int r = 0; r <= NR; r++) begin
        compared++;
        if (wrCnt[r] != NR || gotRow(r) !== expRow(r)) begin
          mismatched++;
          $display("[TB] FAIL rand_fifo%0d: got %h (%0d writes) want %h (8 writes)", r, gotRow(r), wrCnt[r], expRow(r));
        end
      end
    end
    cfgWait = 0; cfgLat = 1;
  endtask

  task automatic test_fifo_full();
    randomMemory();
    fullArm = 1; fullLeft = 5;
    launch();
    waitDone(200);
    fullArm = 0;
    compared++; if (doneCycle != 96) begin mismatched++; $display("[TB] FAIL full_done_cycle: got %0d want 96", doneCycle); end
    compared++; if (byte2Cycle != 40) begin mismatched++; $display("[TB] FAIL full_byte2_cycle: got %0d want 40", byte2Cycle); end
    for (int r = 0; r <= NR; r++) begin
      compared++;
      if (wrCnt[r] != NR || gotRow(r) !== expRow(r)) begin
        mismatched++;
        $display("[TB] FAIL full_fifo%0d: got %h (%0d writes) want %h (8 writes)", r, gotRow(r), wrCnt[r], expRow(r));
      end
    end
  endtask

  task automatic test_start_ignored();
    randomMemory();
    launch();
    while (cyc - startBase < 20) begin @(posedge clk); #2; end
    start = 1;
    @(posedge clk); #2;
    start = 0;
    waitDone(200);
    compared++; if (writeTotal != 72) begin mismatched++; $display("[TB] FAIL busy_start_writes: got %0d want 72", writeTotal); end
    compared++; if (doneCount != 1) begin mismatched++; $display("[TB] FAIL busy_start_done_count: got %0d want 1", doneCount); end
    compared++; if (doneCycle != 91) begin mismatched++; $display("[TB] FAIL busy_start_done_cycle: got %0d want 91", doneCycle); end
  endtask

  task automatic test_reset_midload();
    randomMemory();
    launch();
    while (cyc - startBase < 40) begin @(posedge clk); #2; end
    #1;
    rst_n = 0;
    #1;
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_read !== 1'b0 || mem_address !== AW'(BASE) || fifo_wrreq !== '0 || fifo_wdata !== '0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: busy=%b done=%b read=%b addr=%h wrreq=%b wdata=%h, want all zero",
               busy, done, mem_read, mem_address, fifo_wrreq, fifo_wdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    randomMemory();
    launch();
    waitDone(200);
    compared++; if (firstAddr !== AW'(BASE)) begin mismatched++; $display("[TB] FAIL midreset_first_addr: got %h want %h", firstAddr, AW'(BASE)); end
    compared++; if (doneCycle != 91) begin mismatched++; $display("[TB] FAIL midreset_done_cycle: got %0d want 91", doneCycle); end
    for (int r = 0; r <= NR; r++) begin
      compared++;
      if (wrCnt[r] != NR || gotRow(r) !== expRow(r)) begin
        mismatched++;
        $display("[TB] FAIL midreset_fifo%0d: got %h (%0d writes) want %h (8 writes)", r, gotRow(r), wrCnt[r], expRow(r));
      end
    end
  endtask

  initial begin
    compared = 0; mismatched = 0; startBase = 0;
    rst_n = 0; start = 0;
    test_reset();
    test_no_stall();
    test_mem_stalls();
    test_random_stalls();
    test_fifo_full();
    test_start_ignored();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
